// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - issue queue for divide instructions between dispatch and the divider
//
// Purpose
//   Holds up to DEPTH waiting divides in a collapsing queue (entry 0 is the
//   oldest), wakes their source operands from CDB broadcasts, discards entries
//   younger than a mispredicted branch, and issues the oldest ready entry
//   whenever the divider can accept one.
//
// Optional feature
//   DIV_IQ_BYPASS_EN : when defined, a source matching the current CDB
//   broadcast counts as ready for eligibility in the same cycle (the register
//   file must then be write-through). When undefined, a wakeup makes an entry
//   eligible from the next cycle on.
//
// Parameters
//   DEPTH  number of queue entries (2..8)
//   TAG_W  ROB tag width
//   PHY_W  physical register address width
//
// Ports
//   Clk, Resetb                          clock, asynchronous active-low reset
//   Dis_DivIssue, Dis_RobTag,
//   Dis_Rs/RtPhyAddr, Dis_Rs/RtReady,
//   Dis_RdPhyAddr, Dis_RdWrite           dispatch write port
//   Iq_DivFull                           all entries valid, dispatch must hold
//   Cdb_Valid, Cdb_RdPhyAddr,
//   Cdb_RdWrite                          CDB broadcast used for wakeup
//   Cdb_Flush, Rob_TopPtr, Cdb_RobDepth  mispredict flush by age
//   Div_ExeRdy                           divider can take a divide this cycle
//   Iss_Div, Iss_RobTag, Iss_Rs/RtPhyAddr,
//   Iss_RdPhyAddr, Iss_RdWrite           issue port (zero when Iss_Div=0)

module div_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int PHY_W = 6
) (
  input  logic             Clk,
  input  logic             Resetb,
  input  logic             Dis_DivIssue,
  input  logic [TAG_W-1:0] Dis_RobTag,
  input  logic [PHY_W-1:0] Dis_RsPhyAddr,
  input  logic             Dis_RsReady,
  input  logic [PHY_W-1:0] Dis_RtPhyAddr,
  input  logic             Dis_RtReady,
  input  logic [PHY_W-1:0] Dis_RdPhyAddr,
  input  logic             Dis_RdWrite,
  output logic             Iq_DivFull,
  input  logic             Cdb_Valid,
  input  logic [PHY_W-1:0] Cdb_RdPhyAddr,
  input  logic             Cdb_RdWrite,
  input  logic             Cdb_Flush,
  input  logic [TAG_W-1:0] Rob_TopPtr,
  input  logic [TAG_W-1:0] Cdb_RobDepth,
  input  logic             Div_ExeRdy,
  output logic             Iss_Div,
  output logic [TAG_W-1:0] Iss_RobTag,
  output logic [PHY_W-1:0] Iss_RsPhyAddr,
  output logic [PHY_W-1:0] Iss_RtPhyAddr,
  output logic [PHY_W-1:0] Iss_RdPhyAddr,
  output logic             Iss_RdWrite
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PHY_W-1:0] rs;
    logic             rs_rdy;
    logic [PHY_W-1:0] rt;
    logic             rt_rdy;
    logic [PHY_W-1:0] rd;
    logic             rd_write;
  } entry_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];

  // Per-entry status derived from the registers and this cycle's inputs.
  logic [TAG_W-1:0] age      [DEPTH];
  entry_t           woken    [DEPTH];
  logic [DEPTH-1:0] flushed;
  logic [DEPTH-1:0] rs_hit;
  logic [DEPTH-1:0] rt_hit;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] keep;

  logic   cdb_wake;
  logic   iss_go;
  logic   dis_accept;
  entry_t dis_ent;

  assign cdb_wake = Cdb_Valid & Cdb_RdWrite;

  // The queue collapses on every removal, so it is full exactly when the
  // top slot holds a valid entry.
  assign Iq_DivFull = valid_q[DEPTH-1];

  // Age, flush, wakeup and eligibility for every stored entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // Modulo-2**TAG_W subtraction handles ROB tag wrap around the head.
      age[i]     = ent_q[i].tag - Rob_TopPtr;
      flushed[i] = valid_q[i] & Cdb_Flush & (age[i] > Cdb_RobDepth);
      rs_hit[i]  = cdb_wake & (ent_q[i].rs == Cdb_RdPhyAddr);
      rt_hit[i]  = cdb_wake & (ent_q[i].rt == Cdb_RdPhyAddr);

      woken[i]        = ent_q[i];
      woken[i].rs_rdy = ent_q[i].rs_rdy | rs_hit[i];
      woken[i].rt_rdy = ent_q[i].rt_rdy | rt_hit[i];

`ifdef DIV_IQ_BYPASS_EN
      elig[i] = valid_q[i] & woken[i].rs_rdy & woken[i].rt_rdy & ~flushed[i];
`else
      elig[i] = valid_q[i] & ent_q[i].rs_rdy & ent_q[i].rt_rdy & ~flushed[i];
`endif
    end
  end

  // Oldest-first select: lowest eligible index wins.
  always_comb begin
    logic found;
    found  = 1'b0;
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !found) begin
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign iss_go = Div_ExeRdy & (|elig);

  // Issue port: one-hot OR mux of the selected entry, all zero when idle.
  always_comb begin
    Iss_Div       = iss_go;
    Iss_RobTag    = '0;
    Iss_RsPhyAddr = '0;
    Iss_RtPhyAddr = '0;
    Iss_RdPhyAddr = '0;
    Iss_RdWrite   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_go && sel_oh[i]) begin
        Iss_RobTag    = Iss_RobTag    | ent_q[i].tag;
        Iss_RsPhyAddr = Iss_RsPhyAddr | ent_q[i].rs;
        Iss_RtPhyAddr = Iss_RtPhyAddr | ent_q[i].rt;
        Iss_RdPhyAddr = Iss_RdPhyAddr | ent_q[i].rd;
        Iss_RdWrite   = Iss_RdWrite   | ent_q[i].rd_write;
      end
    end
  end

  // An entry survives the edge unless it is flushed or issued now.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = valid_q[i] & ~flushed[i] & ~(iss_go & sel_oh[i]);
    end
  end

  // Incoming entry also sees a same-cycle broadcast so its wakeup is not lost.
  always_comb begin
    dis_ent.tag      = Dis_RobTag;
    dis_ent.rs       = Dis_RsPhyAddr;
    dis_ent.rs_rdy   = Dis_RsReady | (cdb_wake & (Dis_RsPhyAddr == Cdb_RdPhyAddr));
    dis_ent.rt       = Dis_RtPhyAddr;
    dis_ent.rt_rdy   = Dis_RtReady | (cdb_wake & (Dis_RtPhyAddr == Cdb_RdPhyAddr));
    dis_ent.rd       = Dis_RdPhyAddr;
    dis_ent.rd_write = Dis_RdWrite;
  end

  // Fullness is judged on the registered state, so a dispatch in a cycle
  // that also issues from a full queue is still dropped.
  assign dis_accept = Dis_DivIssue & ~Iq_DivFull & ~Cdb_Flush;

  // Compaction: the k-th surviving entry moves to slot k, then a dispatched
  // entry lands directly above the survivors, preserving age order.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int j = 0; j < DEPTH; j++) begin
      valid_d[j] = 1'b0;
      ent_d[j]   = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (cnt == j) begin
            valid_d[j] = 1'b1;
            ent_d[j]   = woken[i];
          end
        end
        cnt = cnt + 1;
      end
    end
    if (dis_accept) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (cnt == j) begin
          valid_d[j] = 1'b1;
          ent_d[j]   = dis_ent;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// tb/tb_div_issue_queue.sv - self-checking bench for div_issue_queue

module tb_div_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int PHY_W = 6;

  logic             Clk = 1'b0;
  logic             Resetb;
  logic             Dis_DivIssue;
  logic [TAG_W-1:0] Dis_RobTag;
  logic [PHY_W-1:0] Dis_RsPhyAddr;
  logic             Dis_RsReady;
  logic [PHY_W-1:0] Dis_RtPhyAddr;
  logic             Dis_RtReady;
  logic [PHY_W-1:0] Dis_RdPhyAddr;
  logic             Dis_RdWrite;
  logic             Iq_DivFull;
  logic             Cdb_Valid;
  logic [PHY_W-1:0] Cdb_RdPhyAddr;
  logic             Cdb_RdWrite;
  logic             Cdb_Flush;
  logic [TAG_W-1:0] Rob_TopPtr;
  logic [TAG_W-1:0] Cdb_RobDepth;
  logic             Div_ExeRdy;
  logic             Iss_Div;
  logic [TAG_W-1:0] Iss_RobTag;
  logic [PHY_W-1:0] Iss_RsPhyAddr;
  logic [PHY_W-1:0] Iss_RtPhyAddr;
  logic [PHY_W-1:0] Iss_RdPhyAddr;
  logic             Iss_RdWrite;

  always #5 Clk = ~Clk;

  div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PHY_W(PHY_W)) dut (
    .Clk(Clk), .Resetb(Resetb),
    .Dis_DivIssue(Dis_DivIssue), .Dis_RobTag(Dis_RobTag),
    .Dis_RsPhyAddr(Dis_RsPhyAddr), .Dis_RsReady(Dis_RsReady),
    .Dis_RtPhyAddr(Dis_RtPhyAddr), .Dis_RtReady(Dis_RtReady),
    .Dis_RdPhyAddr(Dis_RdPhyAddr), .Dis_RdWrite(Dis_RdWrite),
    .Iq_DivFull(Iq_DivFull),
    .Cdb_Valid(Cdb_Valid), .Cdb_RdPhyAddr(Cdb_RdPhyAddr), .Cdb_RdWrite(Cdb_RdWrite),
    .Cdb_Flush(Cdb_Flush), .Rob_TopPtr(Rob_TopPtr), .Cdb_RobDepth(Cdb_RobDepth),
    .Div_ExeRdy(Div_ExeRdy),
    .Iss_Div(Iss_Div), .Iss_RobTag(Iss_RobTag),
    .Iss_RsPhyAddr(Iss_RsPhyAddr), .Iss_RtPhyAddr(Iss_RtPhyAddr),
    .Iss_RdPhyAddr(Iss_RdPhyAddr), .Iss_RdWrite(Iss_RdWrite)
  );

  // Reference model: an ordered list of waiting divides, oldest first.
  typedef struct {
    int tag;
    int rs;
    bit rsr;
    int rt;
    bit rtr;
    int rd;
    bit rdw;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int addr);
    return Cdb_Valid && Cdb_RdWrite && (addr == int'(Cdb_RdPhyAddr));
  endfunction

  function automatic bit m_flushed(input int tag);
    int age;
    age = (tag + (1 << TAG_W) - int'(Rob_TopPtr)) % (1 << TAG_W);
    return Cdb_Flush && (age > int'(Cdb_RobDepth));
  endfunction

  function automatic bit m_src_ok(input bit rdy, input int addr);
`ifdef DIV_IQ_BYPASS_EN
    return rdy || m_hit(addr);
`else
    return rdy && (addr >= 0);
`endif
  endfunction

  // Compare DUT outputs against the model for the current inputs, then
  // advance the model across the next clock edge.
  task automatic cycle();
    int   sel;
    bit   exp_iss;
    ent_t nq[$];
    ent_t e;
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && m_src_ok(mq[i].rsr, mq[i].rs) && m_src_ok(mq[i].rtr, mq[i].rt)
          && !m_flushed(mq[i].tag))
        sel = i;
    end
    exp_iss = Div_ExeRdy && (sel >= 0);
    chk("Iq_DivFull", 32'(Iq_DivFull), 32'(mq.size() == DEPTH));
    chk("Iss_Div", 32'(Iss_Div), 32'(exp_iss));
    if (exp_iss) begin
      chk("Iss_RobTag", 32'(Iss_RobTag), mq[sel].tag);
      chk("Iss_RsPhyAddr", 32'(Iss_RsPhyAddr), mq[sel].rs);
      chk("Iss_RtPhyAddr", 32'(Iss_RtPhyAddr), mq[sel].rt);
      chk("Iss_RdPhyAddr", 32'(Iss_RdPhyAddr), mq[sel].rd);
      chk("Iss_RdWrite", 32'(Iss_RdWrite), 32'(mq[sel].rdw));
    end else begin
      chk("Iss_bus_idle", {Iss_RobTag, Iss_RsPhyAddr, Iss_RtPhyAddr, Iss_RdPhyAddr, Iss_RdWrite}, 0);
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!(exp_iss && i == sel) && !m_flushed(mq[i].tag)) begin
        e = mq[i];
        e.rsr = e.rsr || m_hit(e.rs);
        e.rtr = e.rtr || m_hit(e.rt);
        nq.push_back(e);
      end
    end
    if (Dis_DivIssue && !Cdb_Flush && mq.size() < DEPTH) begin
      e.tag = int'(Dis_RobTag);
      e.rs  = int'(Dis_RsPhyAddr);
      e.rsr = Dis_RsReady || m_hit(int'(Dis_RsPhyAddr));
      e.rt  = int'(Dis_RtPhyAddr);
      e.rtr = Dis_RtReady || m_hit(int'(Dis_RtPhyAddr));
      e.rd  = int'(Dis_RdPhyAddr);
      e.rdw = Dis_RdWrite;
      nq.push_back(e);
    end
    @(negedge Clk);
    mq = nq;
  endtask

  task automatic idle();
    Dis_DivIssue = 0; Dis_RobTag = '0; Dis_RsPhyAddr = '0; Dis_RsReady = 0;
    Dis_RtPhyAddr = '0; Dis_RtReady = 0; Dis_RdPhyAddr = '0; Dis_RdWrite = 0;
    Cdb_Valid = 0; Cdb_RdPhyAddr = '0; Cdb_RdWrite = 0; Cdb_Flush = 0;
    Rob_TopPtr = '0; Cdb_RobDepth = '0; Div_ExeRdy = 0;
  endtask

  task automatic dispatch(input int tag, input int rs, input bit rsr, input int rt, input bit rtr,
                          input int rd, input bit rdw);
    Dis_DivIssue  = 1;
    Dis_RobTag    = TAG_W'(tag);
    Dis_RsPhyAddr = PHY_W'(rs);
    Dis_RsReady   = rsr;
    Dis_RtPhyAddr = PHY_W'(rt);
    Dis_RtReady   = rtr;
    Dis_RdPhyAddr = PHY_W'(rd);
    Dis_RdWrite   = rdw;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    Resetb = 0;
    repeat (2) @(negedge Clk);
    Div_ExeRdy = 1;
    settle();
    chk("reset_iss_div", 32'(Iss_Div), 0);
    chk("reset_full", 32'(Iq_DivFull), 0);
    chk("reset_bus", {Iss_RobTag, Iss_RsPhyAddr, Iss_RtPhyAddr, Iss_RdPhyAddr, Iss_RdWrite}, 0);
    @(negedge Clk);
    Resetb = 1;
    mq.delete();

    // Ready divide issues the cycle after dispatch, then the queue is empty.
    idle(); dispatch(3, 1, 1, 2, 1, 9, 1); Div_ExeRdy = 1; settle();
    chk("t1_empty_first", 32'(Iss_Div), 0);
    cycle();
    idle(); Div_ExeRdy = 1; settle();
    chk("t1_iss", 32'(Iss_Div), 1);
    chk("t1_tag", 32'(Iss_RobTag), 3);
    chk("t1_rd", 32'(Iss_RdPhyAddr), 9);
    cycle();
    idle(); Div_ExeRdy = 1; settle();
    chk("t1_after", 32'(Iss_Div), 0);
    cycle();

    // Wakeup of Rs=12 by a writing broadcast.
    idle(); dispatch(4, 12, 0, 13, 1, 5, 1); settle(); cycle();
    idle(); Cdb_Valid = 1; Cdb_RdPhyAddr = 12; Cdb_RdWrite = 1; Div_ExeRdy = 1; settle();
`ifdef DIV_IQ_BYPASS_EN
    chk("t2_iss_t", 32'(Iss_Div), 1);
    chk("t2_tag_t", 32'(Iss_RobTag), 4);
`else
    chk("t2_iss_t", 32'(Iss_Div), 0);
`endif
    cycle();
    idle(); Div_ExeRdy = 1; settle();
`ifdef DIV_IQ_BYPASS_EN
    chk("t2_iss_t1", 32'(Iss_Div), 0);
`else
    chk("t2_iss_t1", 32'(Iss_Div), 1);
    chk("t2_tag_t1", 32'(Iss_RobTag), 4);
`endif
    cycle();

    // Broadcast without RdWrite must not wake.
    idle(); dispatch(7, 12, 0, 13, 1, 5, 1); settle(); cycle();
    idle(); Cdb_Valid = 1; Cdb_RdPhyAddr = 12; Cdb_RdWrite = 0; Div_ExeRdy = 1; settle();
    chk("t3_iss_t", 32'(Iss_Div), 0);
    cycle();
    idle(); Div_ExeRdy = 1; settle();
    chk("t3_iss_t1", 32'(Iss_Div), 0);
    cycle();
    idle(); Resetb = 0; settle(); cycle();
    Resetb = 1; mq.delete();

    // Oldest first under a stalled divider.
    idle(); dispatch(5, 1, 1, 2, 1, 3, 1); settle(); cycle();
    idle(); dispatch(6, 1, 1, 2, 1, 4, 0); settle(); cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); settle(); chk("t4_stall", 32'(Iss_Div), 0); cycle();
    end
    idle(); Div_ExeRdy = 1; settle();
    chk("t4_first", 32'(Iss_RobTag), 5);
    cycle();
    for (int k = 0; k < 6; k++) begin
      idle(); settle(); cycle();
    end
    idle(); Div_ExeRdy = 1; settle();
    chk("t4_second_iss", 32'(Iss_Div), 1);
    chk("t4_second", 32'(Iss_RobTag), 6);
    cycle();

    // Full, conservative full during issue, dropped write, in-order refill.
    idle(); dispatch(10, 1, 1, 2, 1, 7, 1); settle(); cycle();
    for (int k = 11; k <= 13; k++) begin
      idle(); dispatch(k, 40, 0, 2, 1, 7, 1); settle(); cycle();
    end
    idle(); settle();
    chk("t5_full", 32'(Iq_DivFull), 1);
    cycle();
    idle(); Div_ExeRdy = 1; dispatch(20, 1, 1, 2, 1, 7, 1); settle();
    chk("t5_full_during_iss", 32'(Iq_DivFull), 1);
    chk("t5_iss_tag", 32'(Iss_RobTag), 10);
    cycle();
    idle(); dispatch(14, 40, 0, 2, 1, 7, 1); settle();
    chk("t5_not_full", 32'(Iq_DivFull), 0);
    cycle();
    idle(); Cdb_Valid = 1; Cdb_RdPhyAddr = 40; Cdb_RdWrite = 1; settle();
    chk("t5_refull", 32'(Iq_DivFull), 1);
    cycle();
    for (int k = 0; k < 4; k++) begin
      idle(); Div_ExeRdy = 1; settle();
      chk("t5_order", 32'(Iss_RobTag), 32'(11 + k));
      cycle();
    end
    idle(); Div_ExeRdy = 1; settle();
    chk("t5_drop", 32'(Iss_Div), 0);
    cycle();

    // Flush across tag wrap: TopPtr=30, tag 31 age 1 stays, tag 2 age 4 goes.
    idle(); Rob_TopPtr = 30; dispatch(31, 1, 1, 2, 1, 3, 1); settle(); cycle();
    idle(); Rob_TopPtr = 30; dispatch(2, 1, 1, 2, 1, 4, 1); settle(); cycle();
    idle(); Cdb_Flush = 1; Rob_TopPtr = 30; Cdb_RobDepth = 2; settle(); cycle();
    idle(); Div_ExeRdy = 1; settle();
    chk("t6_survivor", 32'(Iss_RobTag), 31);
    cycle();
    idle(); Div_ExeRdy = 1; settle();
    chk("t6_flushed_gone", 32'(Iss_Div), 0);
    cycle();

    // Asynchronous reset with valid entries.
    for (int k = 0; k < 4; k++) begin
      idle(); dispatch(20 + k, 1, 1, 2, 1, 3, 1); settle(); cycle();
    end
    idle(); Div_ExeRdy = 1; settle();
    chk("t7_pre_iss", 32'(Iss_Div), 1);
    chk("t7_pre_full", 32'(Iq_DivFull), 1);
    Resetb = 0; #1;
    chk("t7_rst_iss", 32'(Iss_Div), 0);
    chk("t7_rst_full", 32'(Iq_DivFull), 0);
    @(negedge Clk);
    Resetb = 1; mq.delete();
    idle(); Div_ExeRdy = 1; settle();
    chk("t7_empty", 32'(Iss_Div), 0);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      Dis_DivIssue  = 1'($urandom_range(0, 1));
      Dis_RobTag    = TAG_W'($urandom);
      Dis_RsPhyAddr = PHY_W'($urandom_range(0, 7));
      Dis_RsReady   = ($urandom_range(0, 2) == 0);
      Dis_RtPhyAddr = PHY_W'($urandom_range(0, 7));
      Dis_RtReady   = ($urandom_range(0, 2) == 0);
      Dis_RdPhyAddr = PHY_W'($urandom);
      Dis_RdWrite   = 1'($urandom_range(0, 1));
      Cdb_Valid     = ($urandom_range(0, 9) < 4);
      Cdb_RdPhyAddr = PHY_W'($urandom_range(0, 7));
      Cdb_RdWrite   = ($urandom_range(0, 3) != 0);
      Cdb_Flush     = ($urandom_range(0, 19) == 0);
      Rob_TopPtr    = TAG_W'($urandom);
      Cdb_RobDepth  = TAG_W'($urandom);
      Div_ExeRdy    = ($urandom_range(0, 2) == 0);
      settle();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
